// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Bundle between the five-stage datapath and its hazard/sequencing controller.
//   There is no valid/ready handshake on this bundle. Every signal is a
//   level sampled each cycle. The datapath drives the hazard-status inputs.
//   The controller drives the latch/PC controls and its registered status.
//
//   Datapath -> controller:
//     ihit, dhit, mem_dREN, mem_dWEN, mem_beq, mem_bne, mem_zero,
//     mem_jump, mem_halt, ex_dREN, ex_wsel[4:0], id_rs[4:0], id_rt[4:0],
//     id_uses_rt
//   Controller -> datapath:
//     pc_en, pc_sel[1:0], fetch_en, decode_en, execute_en, memory_en,
//     fetch_flush, decode_flush, execute_flush, halt,
//     stall_cnt[15:0], redirect_cnt[15:0]
//     state[1:0]  (debug view of the controller FSM: 0 RUN, 1 DSTALL, 2 HALTED)
interface pipeline_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       mem_dREN;
    logic       mem_dWEN;
    logic       mem_beq;
    logic       mem_bne;
    logic       mem_zero;
    logic       mem_jump;
    logic       mem_halt;
    logic       ex_dREN;
    logic [4:0] ex_wsel;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;

    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        fetch_en;
    logic        decode_en;
    logic        execute_en;
    logic        memory_en;
    logic        fetch_flush;
    logic        decode_flush;
    logic        execute_flush;
    logic        halt;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;
    logic [1:0]  state;

    // Datapath side.
    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_beq, mem_bne, mem_zero,
               mem_jump, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt,
        input  pc_en, pc_sel, fetch_en, decode_en, execute_en, memory_en,
               fetch_flush, decode_flush, execute_flush, halt,
               stall_cnt, redirect_cnt, state
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_beq, mem_bne, mem_zero,
               mem_jump, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt,
        output pc_en, pc_sel, fetch_en, decode_en, execute_en, memory_en,
               fetch_flush, decode_flush, execute_flush, halt,
               stall_cnt, redirect_cnt, state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and sequencing controller for the five-stage pipeline. It drives
//   the IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes, the PC
//   enable and PC source select. It resolves cache-miss stalls, load-use
//   bubbles, memory-stage branch/jump redirects and the terminal halt. It also
//   keeps saturating stall and redirect counters.
//
//   Ports:
//     CLK  pipeline clock, rising edge
//     RST  synchronous active-high reset
//     bus  pipeline_ctrl_if.slave (hazard status in, latch/PC controls out)
module pipeline_ctrl (
    input  logic               CLK,
    input  logic               RST,
    pipeline_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DSTALL  = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t state, state_n;

    logic        halt_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] redirect_cnt_q;

    logic dmem, taken, redirect, advance, lu;
    logic lu_bubble, stall_inc, redirect_inc;

    logic       pc_en_c;
    logic [1:0] pc_sel_c;
    logic       fetch_en_c, decode_en_c, execute_en_c, memory_en_c;
    logic       fetch_flush_c, decode_flush_c, execute_flush_c;

    // ---------------------------------------------------------------
    // Hazard terms
    // ---------------------------------------------------------------
    assign dmem     = bus.mem_dREN | bus.mem_dWEN;
    assign taken    = (bus.mem_beq & bus.mem_zero) | (bus.mem_bne & ~bus.mem_zero);
    assign redirect = taken | bus.mem_jump;
    // mem_halt freezes everything, which also suppresses any redirect.
    assign advance  = bus.ihit & (~dmem | bus.dhit) & ~bus.mem_halt;

    // $zero is never a real destination, so a load into it cannot cause a hazard.
    assign lu = bus.ex_dREN & (bus.ex_wsel != 5'd0) &
                ((bus.ex_wsel == bus.id_rs) |
                 (bus.id_uses_rt & (bus.ex_wsel == bus.id_rt)));

    // A redirect flushes the dependent decode-stage instruction anyway, so it
    // takes priority over the bubble.
    assign lu_bubble    = advance & ~redirect & lu;
    assign stall_inc    = ~advance | lu_bubble;
    assign redirect_inc = advance & redirect;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RUN;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            ST_RUN: begin
                if (bus.mem_halt) begin
                    state_n = ST_HALTED;
                end else if (dmem & ~bus.dhit) begin
                    state_n = ST_DSTALL;
                end
            end
            ST_DSTALL: begin
                if (bus.mem_halt) begin
                    state_n = ST_HALTED;
                end else if (bus.dhit) begin
                    state_n = ST_RUN;
                end
            end
            ST_HALTED: state_n = ST_HALTED;
            default:   state_n = ST_RUN;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (combinational, same-cycle)
    // ---------------------------------------------------------------
    always_comb begin
        pc_en_c         = 1'b0;
        pc_sel_c        = 2'b00;
        fetch_en_c      = 1'b0;
        decode_en_c     = 1'b0;
        execute_en_c    = 1'b0;
        memory_en_c     = 1'b0;
        fetch_flush_c   = 1'b0;
        decode_flush_c  = 1'b0;
        execute_flush_c = 1'b0;

        if (RST) begin
            // Clear every latch at the reset edge; PC is reset on its own.
            fetch_en_c      = 1'b1;
            decode_en_c     = 1'b1;
            execute_en_c    = 1'b1;
            memory_en_c     = 1'b1;
            fetch_flush_c   = 1'b1;
            decode_flush_c  = 1'b1;
            execute_flush_c = 1'b1;
        end else if ((state != ST_HALTED) && advance) begin
            fetch_en_c   = 1'b1;
            decode_en_c  = 1'b1;
            execute_en_c = 1'b1;
            memory_en_c  = 1'b1;
            pc_en_c      = 1'b1;
            if (redirect) begin
                // Three younger instructions are on the wrong path.
                fetch_flush_c   = 1'b1;
                decode_flush_c  = 1'b1;
                execute_flush_c = 1'b1;
                pc_sel_c        = taken ? 2'b01 : 2'b10;
            end else if (lu) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                pc_en_c        = 1'b0;
                fetch_en_c     = 1'b0;
                decode_flush_c = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered status and saturating counters
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_q         <= 1'b0;
            stall_cnt_q    <= 16'd0;
            redirect_cnt_q <= 16'd0;
        end else begin
            halt_q <= (state_n == ST_HALTED);
            if (state != ST_HALTED) begin
                if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_q <= stall_cnt_q + 16'd1;
                end
                if (redirect_inc && (redirect_cnt_q != 16'hFFFF)) begin
                    redirect_cnt_q <= redirect_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.pc_en         = pc_en_c;
    assign bus.pc_sel        = pc_sel_c;
    assign bus.fetch_en      = fetch_en_c;
    assign bus.decode_en     = decode_en_c;
    assign bus.execute_en    = execute_en_c;
    assign bus.memory_en     = memory_en_c;
    assign bus.fetch_flush   = fetch_flush_c;
    assign bus.decode_flush  = decode_flush_c;
    assign bus.execute_flush = execute_flush_c;
    assign bus.halt          = halt_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.redirect_cnt  = redirect_cnt_q;
    assign bus.state         = state;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. Drives the per-latch enable and flush controls of the fetch, decode, execute and memory pipeline latches. Produces the PC enable and PC source select. Resolves cache-miss stalls, load-use bubbles, branch/jump redirects from the memory stage, and the terminal halt. Also keeps two saturating performance counters.

## Interface
- No parameters.
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- ihit  in  1  instruction fetch for current PC completes this cycle.
- dhit  in  1  memory-stage data access completes this cycle.
- mem_dREN, mem_dWEN  in  1  memory stage holds a load / store (execute-latch dRENo/dWENo).
- mem_beq, mem_bne, mem_zero  in  1  memory-stage branch type and ALU zero flag.
- mem_jump  in  1  memory stage holds j/jal/jr (jsigo | jrsigo).
- mem_halt  in  1  memory stage holds halt.
- ex_dREN  in  1  execute stage holds a load.
- ex_wsel  in  5  destination register of the execute-stage instruction.
- id_rs, id_rt  in  5  source registers of the decode-stage instruction; id_uses_rt in 1 qualifies id_rt.
- pc_en  out  1  PC register load.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target; 11 never driven.
- fetch_en, decode_en, execute_en, memory_en  out  1  latch enables (IF/ID, ID/EX, EX/MEM, MEM/WB).
- fetch_flush, decode_flush, execute_flush  out  1  synchronous latch clears, effective only with the matching enable.
- halt  out  1  registered; processor halted.
- stall_cnt  out  16  saturating count of non-advancing or bubble cycles.
- redirect_cnt  out  16  saturating count of taken redirects.

## Operation
- FSM states: RUN, DSTALL, HALTED. Reset state is RUN.
- Intermediate terms:
  - dmem = mem_dREN | mem_dWEN.
  - taken = (mem_beq & mem_zero) | (mem_bne & ~mem_zero).
  - redirect = taken | mem_jump.
  - advance = ihit & (~dmem | dhit) & ~mem_halt.
- Load-use hazard: lu = ex_dREN & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt)).
- RUN / DSTALL, advance = 0: all enables 0, all flushes 0, pc_en 0, pc_sel 00.
- RUN / DSTALL, advance = 1, redirect = 1:
  - all enables 1, pc_en 1.
  - fetch_flush, decode_flush, execute_flush all 1.
  - pc_sel = 01 if taken, otherwise 10.
  - redirect has priority over lu.
- advance = 1, lu = 1, no redirect:
  - pc_en 0, fetch_en 0 (IF/ID held).
  - decode_en 1 with decode_flush 1 (bubble into ID/EX).
  - execute_en 1, memory_en 1.
- advance = 1, no redirect, no lu: all enables 1, flushes 0, pc_en 1, pc_sel 00.
- Transitions:
  - RUN → DSTALL when dmem & ~dhit.
  - DSTALL → RUN on dhit.
  - Any state except HALTED → HALTED when mem_halt = 1, regardless of ihit/dhit.
  - HALTED is exit-only by RST.
- HALTED: all enables 0, flushes 0, pc_en 0, halt = 1.
- While mem_halt is asserted, no latch advances, so younger instructions never reach MEM/WB.
- mem_halt together with redirect: halt wins, no redirect.
- stall_cnt increments in RUN/DSTALL on any cycle with advance = 0 or an inserted lu bubble. It saturates at 16'hFFFF.
- redirect_cnt increments on each cycle with advance & redirect. It saturates at 16'hFFFF.
- Neither counter changes in HALTED.

## Timing
- All enables, flushes, pc_en and pc_sel are combinational from the current state and inputs, valid in the same cycle.
- halt, state and both counters are registered; they update at the edge ending the cycle.
- halt rises 1 cycle after mem_halt is first sampled.
- While RST = 1: all enables 1, all flushes 1 (every latch cleared at the edge), pc_en 0.
- After RST: state RUN, halt 0, stall_cnt 0, redirect_cnt 0.
- RST mid-stall or mid-halt returns to RUN at the next edge; it has priority over every transition.
- Branch penalty: 3 flushed slots per taken redirect. Load-use penalty: 1 bubble.

## Test plan
- Straight-line, ihit = 1, no dmem: all enables 1, pc_sel 00, stall_cnt stays 0 over 10 cycles.
- Load with dhit low for 3 cycles: state DSTALL, enables 0 for 3 cycles. Advance on the dhit cycle, then RUN. stall_cnt = 3.
- ex_dREN = 1, ex_wsel = 5, id_rs = 5, advance: fetch_en 0, decode_flush 1, pc_en 0, stall_cnt +1. Same stimulus with ex_wsel = 0: no bubble.
- mem_bne = 1, mem_zero = 0 together with lu: pc_sel 01, three flushes 1, fetch_en 1, redirect_cnt = 1. With mem_jump instead: pc_sel 10.
- mem_halt = 1 with ihit = 0: enables 0 that cycle, halt = 1 next cycle and stays 1. Counters frozen. RST → halt 0, state RUN.
- Force 65,540 stall cycles: stall_cnt saturates at 16'hFFFF.
